// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial BCD A-B via 9's-complement add, end-around carry fix-up, signed-magnitude result.
module bcd_serial_subtractor #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] diff,
   output logic                neg,
   output logic                invalid
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;
   state_t         state, state_nx;
   logic [W-1:0]   ra, rb, acc, acc_nx;
   logic [IW-1:0]  idx;
   logic           c, eac, bad, bad_in, last, c_nx;
   logic [3:0]     d_nx;
   logic [4:0]     s;
   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         bad_in = bad_in | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
   end
   assign last = idx == IW'(DIGITS - 1);
   // one shared decimal digit adder serves both the ADD pass and the FIX increment
   always_comb begin
      s      = (state == ADD) ? 5'(ra[4*idx +: 4]) + 5'(4'd9 - rb[4*idx +: 4]) + 5'(c)
                              : 5'(acc[4*idx +: 4]) + 5'(c);
      c_nx   = s > 5'd9;
      d_nx   = (state == FIX && !eac) ? 4'd9 - acc[4*idx +: 4] : (c_nx ? 4'(s - 5'd10) : s[3:0]);
      acc_nx = acc;
      acc_nx[4*idx +: 4] = d_nx;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? ADD : IDLE;
         ADD:     state_nx = bad ? DONE : (last ? FIX : ADD);
         FIX:     state_nx = last ? DONE : FIX;
         default: state_nx = IDLE;
      endcase
   end
   // an invalid request parks one cycle in ADD without asserting busy so done lands after edge 1
   always_comb begin
      busy = (state == ADD && !bad) || state == FIX;
      done = state == DONE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra <= '0; rb <= '0; acc <= '0; idx <= '0; c <= 1'b0; eac <= 1'b0; bad <= 1'b0;
         diff <= '0; neg <= 1'b0; invalid <= 1'b0;
      end else if (state == IDLE && start) begin
         ra      <= a;
         rb      <= b;
         acc     <= '0;
         idx     <= '0;
         c       <= 1'b0;
         bad     <= bad_in;
         invalid <= bad_in;
         if (bad_in) begin
            diff <= '0;
            neg  <= 1'b0;
         end
      end else if (state == ADD && !bad) begin
         acc <= acc_nx;
         c   <= last ? 1'b1 : c_nx;
         eac <= last ? c_nx : eac;
         idx <= last ? '0 : idx + 1'b1;
      end else if (state == FIX) begin
         acc <= acc_nx;
         c   <= c_nx;
         idx <= last ? '0 : idx + 1'b1;
         if (last) begin
            diff <= acc_nx;
            neg  <= ~eac & (|acc_nx);
         end
      end
   end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: randomized scoreboard bench; integer reference model checks each done pulse.
module tb_bcd_serial_subtractor;
   localparam int D = 4;
   localparam int W = 4 * D;
   logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, neg, invalid;
   logic [W-1:0] diff;
   typedef struct packed {logic [W-1:0] diff; logic neg; logic inv;} exp_t;
   exp_t q[$];
   exp_t e_mon;
   int checks = 0, failures = 0;

   bcd_serial_subtractor #(.DIGITS(D)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .neg(neg), .invalid(invalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      int r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r = '0;
      for (int i = 0; i < D; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic bit has_bad(input logic [W-1:0] v);
      for (int i = 0; i < D; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      int   d;
      e = '0;
      if (has_bad(av) || has_bad(bv)) begin
         e.inv = 1'b1;
         return e;
      end
      d      = bcd2int(av) - bcd2int(bv);
      e.diff = int2bcd(d < 0 ? -d : d);
      e.neg  = d < 0;
      return e;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] r;
      for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no pending request");
         end else begin
            e_mon = q.pop_front();
            chk("diff", 64'(diff), 64'(e_mon.diff));
            chk("neg", 64'(neg), 64'(e_mon.neg));
            chk("invalid", 64'(invalid), 64'(e_mon.inv));
         end
      end
   end

   task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv, input bit poke_busy, input bit poke_done);
      exp_t e;
      bit   bad;
      int   n, bc;
      e   = model(av, bv);
      bad = e.inv;
      n   = 0;
      bc  = 0;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      forever begin
         if (done || n >= 100) break;
         bc += int'(busy);
         start = poke_busy && n == 3;
         @(posedge clk);
         #1 n++;
      end
      chk("latency", 64'(n), bad ? 64'd1 : 64'(2 * D));
      chk("busy_cycles", 64'(bc), bad ? 64'd0 : 64'(2 * D));
      chk("busy_in_done", 64'(busy), 64'd0);
      start = poke_done;
      @(posedge clk);
      #1 start = 1'b0;
      chk("done_pulse", 64'(done), 64'd0);
      if (poke_done) begin
         repeat (4) begin
            @(posedge clk);
            #1 chk("idle_after_ignored_start", 64'({busy, done}), 64'd0);
         end
         chk("diff_hold", 64'(diff), 64'(e.diff));
      end
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      #1 chk("reset_outputs", 64'({busy, done, diff, neg, invalid}), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      run(16'h0752, 16'h0321, 1'b0, 1'b0);
      run(16'h0321, 16'h0752, 1'b1, 1'b0);
      run(16'h1234, 16'h1234, 1'b0, 1'b0);
      run(16'h9999, 16'h0000, 1'b0, 1'b0);
      run(16'h0000, 16'h9999, 1'b0, 1'b1);
      run(16'h00A1, 16'h0001, 1'b0, 1'b0);
      run(16'h0100, 16'h0001, 1'b0, 1'b0);
      chk("invalid_cleared", 64'(invalid), 64'd0);
      // abandon an operation between edges 4 and 5
      @(negedge clk);
      a = 16'h4321; b = 16'h1234; start = 1'b1;
      q.push_back(model(16'h4321, 16'h1234));
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("async_reset_outputs", 64'({busy, done, diff, neg, invalid}), 64'd0);
      q.delete();
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);
      run(16'h0500, 16'h0001, 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) begin
         ra = rand_bcd();
         rb = rand_bcd();
         if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
         if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
         if ($urandom_range(0, 9) == 0) rb = ra;
         run(ra, rb, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
      repeat (3) @(posedge clk);
      chk("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
